// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: matches PATTERN (MSB received first) on a 1-bit stream.
// Mealy/Moore output, overlapping or restart-on-match, input enable, saturating match counter.
module seq_pattern_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SW = $clog2(PAT_W + 1);

    // Longest suffix of (first s pattern bits + b) that is also a pattern prefix.
    function automatic int kmp_next(input int s, input logic b);
        logic [16:0] seq;
        int          res;
        bit          ok;
        res = 0;
        seq = '0;
        for (int i = 0; i < s; i++) seq[i] = PATTERN[PAT_W-1-i];
        seq[s] = b;
        for (int k = 1; k <= s + 1; k++) begin
            if (k <= PAT_W) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (seq[s+1-k+j] != PATTERN[PAT_W-1-j]) ok = 1'b0;
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    function automatic int border_len();
        int res;
        bit ok;
        res = 0;
        for (int k = 1; k < PAT_W; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (PATTERN[PAT_W-1-j] != PATTERN[k-1-j]) ok = 1'b0;
            if (ok) res = k;
        end
        return res;
    endfunction

    localparam int            BORDER   = border_len();
    localparam logic [SW-1:0] BORDER_S = SW'(BORDER);
    localparam logic [SW-1:0] RESTART  = OVERLAP ? BORDER_S : '0;

    logic [SW-1:0] nxt0 [PAT_W];
    logic [SW-1:0] nxt1 [PAT_W];

    for (genvar g = 0; g < PAT_W; g++) begin : g_tbl
        localparam int N0 = kmp_next(g, 1'b0);
        localparam int N1 = kmp_next(g, 1'b1);
        assign nxt0[g] = SW'(N0);
        assign nxt1[g] = SW'(N1);
    end

    logic [SW-1:0]    s_q, s_d, s_base, step;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             cnt_sat_q, cnt_sat_d;
    logic             hit, match_evt;

    always_comb begin
        s_base = s_q;
        // A completed Moore match resumes from the restart point before consuming the new bit.
        if (MOORE && (s_q == SW'(PAT_W))) s_base = RESTART;
        step = in ? nxt1[s_base] : nxt0[s_base];

        hit       = en & ~rst & (s_q == SW'(PAT_W - 1)) & (in == PATTERN[0]);
        s_d       = s_q;
        match_evt = 1'b0;
        if (en) begin
            if (!MOORE && hit) begin
                s_d       = RESTART;
                match_evt = 1'b1;
            end else begin
                s_d       = step;
                match_evt = MOORE && (step == SW'(PAT_W));
            end
        end

        out = MOORE ? (s_q == SW'(PAT_W)) : hit;

        match_cnt_d = match_cnt_q;
        if (cnt_clr)
            match_cnt_d = '0;
        else if (match_evt && !(&match_cnt_q))
            match_cnt_d = match_cnt_q + 1'b1;
        cnt_sat_d = &match_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            s_q         <= s_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: five configurations share one stimulus stream and are
// compared every cycle against a bit-history reference model, plus literal scenario checks.
module tb_seq_pattern_detector;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, din = 1'b0, cnt_clr = 1'b0;

    logic       dout [NI];
    logic [7:0] dcnt [NI];
    logic       dsat [NI];
    logic [1:0] cnt_d2, cnt_e2;

    always #5 clk = ~clk;

    // A: 1101 overlap Mealy, B: 1101 non-overlap Mealy, C: 1101 overlap Moore,
    // D: 1010 overlap Mealy 2-bit count, E: 1010 non-overlap Moore 2-bit count.
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(dout[0]), .match_cnt(dcnt[0]), .cnt_sat(dsat[0]));
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(dout[1]), .match_cnt(dcnt[1]), .cnt_sat(dsat[1]));
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(dout[2]), .match_cnt(dcnt[2]), .cnt_sat(dsat[2]));
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(dout[3]), .match_cnt(cnt_d2), .cnt_sat(dsat[3]));
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(2)) u_e (
        .clk(clk), .rst(rst), .en(en), .in(din), .cnt_clr(cnt_clr),
        .out(dout[4]), .match_cnt(cnt_e2), .cnt_sat(dsat[4]));

    assign dcnt[3] = {6'b0, cnt_d2};
    assign dcnt[4] = {6'b0, cnt_e2};

    function automatic logic [3:0] pat_of(input int k);
        return (k < 3) ? 4'b1101 : 4'b1010;
    endfunction
    function automatic bit ov_of(input int k);
        return (k == 0 || k == 2 || k == 3);
    endfunction
    function automatic bit moore_of(input int k);
        return (k == 2 || k == 4);
    endfunction
    function automatic int cmax_of(input int k);
        return (k < 3) ? 255 : 3;
    endfunction

    // Reference model: received-bit history since reset (or since the last match when not overlapping).
    logic [15:0] hist [NI];
    int          hlen [NI];
    bit          mo   [NI];
    int          mcnt [NI];

    bit sampled_out [NI];
    int sampled_cnt [NI];
    bit sampled_sat [NI];

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic compare_and_step();
        bit m;
        logic [15:0] h;
        for (int k = 0; k < NI; k++) begin
            h = {hist[k][14:0], din};
            m = en && !rst && (hlen[k] + 1 >= 4) && (h[3:0] == pat_of(k));
            if (armed) begin
                check("out", k, int'(dout[k]), int'(moore_of(k) ? mo[k] : m));
                check("cnt", k, int'(dcnt[k]), mcnt[k]);
                check("sat", k, int'(dsat[k]), int'(mcnt[k] == cmax_of(k)));
            end
            sampled_out[k] = dout[k];
            sampled_cnt[k] = int'(dcnt[k]);
            sampled_sat[k] = dsat[k];
            if (rst) begin
                hist[k] = '0;
                hlen[k] = 0;
                mo[k]   = 1'b0;
                mcnt[k] = 0;
            end else begin
                if (en) begin
                    hist[k] = h;
                    hlen[k] = (hlen[k] < 16) ? hlen[k] + 1 : 16;
                    if (m && !ov_of(k)) hlen[k] = 0;
                    mo[k] = m;
                end
                if (cnt_clr) mcnt[k] = 0;
                else if (m && mcnt[k] < cmax_of(k)) mcnt[k] = mcnt[k] + 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit b, input bit c);
        rst = r; en = e; din = b; cnt_clr = c;
        @(negedge clk);
        compare_and_step();
        @(posedge clk);
        #1;
        if (r) armed = 1'b1;
    endtask

    task automatic reset_cycle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0]  bits8;
    logic [11:0] bits12;
    int          mask [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            hist[k] = '0; hlen[k] = 0; mo[k] = 1'b0; mcnt[k] = 0;
        end
        @(posedge clk);
        #1;

        // Reset state
        reset_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_cnt_a", 0, sampled_cnt[0], 0);
        check("rst_out_c", 2, int'(sampled_out[2]), 0);
        check("rst_sat_d", 3, int'(sampled_sat[3]), 0);

        // 1101101 then a trailing 0: A overlapping, B restart, C Moore one cycle later
        reset_cycle();
        bits8 = 8'b1101_1010;
        for (int k = 0; k < NI; k++) mask[k] = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, bits8[7-i], 1'b0);
            for (int k = 0; k < NI; k++) if (sampled_out[k]) mask[k] |= (1 << i);
        end
        check("t1_mask_a", 0, mask[0], 'b0100_1000);
        check("t2_mask_b", 1, mask[1], 'b0000_1000);
        check("t3_mask_c", 2, mask[2], 'b1001_0000);
        check("t1_cnt_a", 0, sampled_cnt[0], 2);
        check("t2_cnt_b", 1, sampled_cnt[1], 1);
        check("t3_cnt_c", 2, sampled_cnt[2], 2);

        // 101010 on the 1010 detectors
        reset_cycle();
        for (int k = 0; k < NI; k++) mask[k] = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, (i < 6), (i % 2 == 0), 1'b0);
            for (int k = 0; k < NI; k++) if (sampled_out[k]) mask[k] |= (1 << i);
        end
        check("t4_mask_d", 3, mask[3], 'b010_1000);
        check("t4_mask_e", 4, mask[4], 'b001_0000);
        check("t4_cnt_d", 3, sampled_cnt[3], 2);
        check("t4_cnt_e", 4, sampled_cnt[4], 1);

        // Enable gating holds progress; reset discards it
        reset_cycle();
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_gated_hit_a", 0, int'(sampled_out[0]), 1);
        reset_cycle();
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        reset_cycle();
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_rst_nohit_a", 0, int'(sampled_out[0]), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_rst_cnt_a", 0, sampled_cnt[0], 0);

        // Saturation of a 2-bit counter, then clear on a match edge
        reset_cycle();
        bits12 = 12'b1010_1010_1010;
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, bits12[11-i], 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_sat_cnt_d", 3, sampled_cnt[3], 3);
        check("t6_sat_flag_d", 3, int'(sampled_sat[3]), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t6_clr_edge_hit_d", 3, int'(sampled_out[3]), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_clr_cnt_d", 3, sampled_cnt[3], 0);
        check("t6_clr_sat_d", 3, int'(sampled_sat[3]), 0);

        // Randomized traffic with sporadic reset, enable gaps and clears
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
